// File: rtl/gate4_checker_if.sv
// Bundle of the stimulus/result signals around gate4_checker.
// Optional FIRST_* capture signals exist only when GATE4_CHECKER_FIRST_FAIL_EN is defined.
interface gate4_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             START;
    logic             SAMPLE;
    logic             END;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] NOT_IN;
    logic [WIDTH-1:0] OR_IN;
    logic [WIDTH-1:0] AND_IN;
    logic [WIDTH-1:0] XOR_IN;
    logic             BUSY;
    logic             DONE;
    logic             ERR_FLAG;
    logic [3:0]       ERR_MASK;
    logic [CNT_W-1:0] PASS_CNT;
    logic [CNT_W-1:0] FAIL_CNT;
`ifdef GATE4_CHECKER_FIRST_FAIL_EN
    logic [WIDTH-1:0] FIRST_A;
    logic [WIDTH-1:0] FIRST_B;
    logic [CNT_W-1:0] FIRST_IDX;
    logic             FIRST_VLD;

    modport master (
        output START, SAMPLE, END, A, B, NOT_IN, OR_IN, AND_IN, XOR_IN,
        input  BUSY, DONE, ERR_FLAG, ERR_MASK, PASS_CNT, FAIL_CNT,
        input  FIRST_A, FIRST_B, FIRST_IDX, FIRST_VLD
    );
    modport slave (
        input  START, SAMPLE, END, A, B, NOT_IN, OR_IN, AND_IN, XOR_IN,
        output BUSY, DONE, ERR_FLAG, ERR_MASK, PASS_CNT, FAIL_CNT,
        output FIRST_A, FIRST_B, FIRST_IDX, FIRST_VLD
    );
`else
    modport master (
        output START, SAMPLE, END, A, B, NOT_IN, OR_IN, AND_IN, XOR_IN,
        input  BUSY, DONE, ERR_FLAG, ERR_MASK, PASS_CNT, FAIL_CNT
    );
    modport slave (
        input  START, SAMPLE, END, A, B, NOT_IN, OR_IN, AND_IN, XOR_IN,
        output BUSY, DONE, ERR_FLAG, ERR_MASK, PASS_CNT, FAIL_CNT
    );
`endif
endinterface

// File: rtl/gate4_checker.sv
// Response checker for not4/or4/and4/xor4: recomputes expected gate outputs on
// each accepted sample, reports a per-gate mismatch mask and saturating
// pass/fail tallies. Optional first-failure capture: GATE4_CHECKER_FIRST_FAIL_EN.
module gate4_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic            CLK,
    input logic            RST_N,
    gate4_checker_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic             err_flag_q, err_flag_d;
    logic [3:0]       err_mask_q, err_mask_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             accept;
    logic [3:0]       mask;
`ifdef GATE4_CHECKER_FIRST_FAIL_EN
    logic [WIDTH-1:0] first_a_q, first_a_d;
    logic [WIDTH-1:0] first_b_q, first_b_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic             first_vld_q, first_vld_d;
    logic [CNT_W-1:0] smp_idx_q, smp_idx_d;   // index of the next accepted sample
`endif

    // Per-gate mismatch of the current inputs against the reference functions
    always_comb begin
        mask    = '0;
        mask[0] = (bus.NOT_IN != ~bus.A);
        mask[1] = (bus.OR_IN  != (bus.A | bus.B));
        mask[2] = (bus.AND_IN != (bus.A & bus.B));
        mask[3] = (bus.XOR_IN != (bus.A ^ bus.B));
    end

    // Next state and result updates; START only acts outside RUN, so a
    // START+SAMPLE cycle clears without accepting the sample
    always_comb begin
        state_d    = state_q;
        err_flag_d = err_flag_q;
        err_mask_d = err_mask_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        accept     = 1'b0;
`ifdef GATE4_CHECKER_FIRST_FAIL_EN
        first_a_d   = first_a_q;
        first_b_d   = first_b_q;
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
        smp_idx_d   = smp_idx_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.START) begin
                    state_d    = S_RUN;
                    err_flag_d = 1'b0;
                    err_mask_d = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
`ifdef GATE4_CHECKER_FIRST_FAIL_EN
                    first_a_d   = '0;
                    first_b_d   = '0;
                    first_idx_d = '0;
                    first_vld_d = 1'b0;
                    smp_idx_d   = '0;
`endif
                end
            end
            S_RUN: begin
                accept = bus.SAMPLE;
                if (bus.END) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            err_mask_d = mask;
            if (mask == 4'd0) begin
                if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
            end else begin
                err_flag_d = 1'b1;
                if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
            end
`ifdef GATE4_CHECKER_FIRST_FAIL_EN
            if (mask != 4'd0 && !first_vld_q) begin
                first_a_d   = bus.A;
                first_b_d   = bus.B;
                first_idx_d = smp_idx_q;
                first_vld_d = 1'b1;
            end
            if (smp_idx_q != CNT_MAX) smp_idx_d = smp_idx_q + 1'b1;
`endif
        end
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            err_flag_q <= 1'b0;
            err_mask_q <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
`ifdef GATE4_CHECKER_FIRST_FAIL_EN
            first_a_q   <= '0;
            first_b_q   <= '0;
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
            smp_idx_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            err_flag_q <= err_flag_d;
            err_mask_q <= err_mask_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
`ifdef GATE4_CHECKER_FIRST_FAIL_EN
            first_a_q   <= first_a_d;
            first_b_q   <= first_b_d;
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
            smp_idx_q   <= smp_idx_d;
`endif
        end
    end

    assign bus.BUSY     = (state_q == S_RUN);
    assign bus.DONE     = (state_q == S_DONE);
    assign bus.ERR_FLAG = err_flag_q;
    assign bus.ERR_MASK = err_mask_q;
    assign bus.PASS_CNT = pass_cnt_q;
    assign bus.FAIL_CNT = fail_cnt_q;
`ifdef GATE4_CHECKER_FIRST_FAIL_EN
    assign bus.FIRST_A   = first_a_q;
    assign bus.FIRST_B   = first_b_q;
    assign bus.FIRST_IDX = first_idx_q;
    assign bus.FIRST_VLD = first_vld_q;
`endif
endmodule
